// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one fixed-latency adder; ADDER_ARB_SAT_EN enables saturating sums
module adder_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_start,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic                  busy
);
    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDXW-1:0]  ptr, gid, grant_idx, scan_idx;
    logic             grant_found;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       lat_cnt;
    logic [WIDTH-1:0] op_a, op_b, res_sum;
    logic             res_cout;
    logic             req_hs, rsp_hs;

    // Round-robin search: first valid requester at or above ptr, wrapping modulo NREQ
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = IDXW'((int'(ptr) + i) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDXW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant is withheld while reset is asserted so every output reads zero during reset
    assign req_hs = rst && (state == IDLE) && grant_found;
    assign rsp_hs = (state == RESP) && rsp_ready[gid];

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_start = 1'b0;
        rsp_valid = '0;
        rsp_sum   = '0;
        rsp_cout  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (req_hs) begin
                    req_ready = NREQ'(1) << grant_idx;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                add_a     = op_a;
                add_b     = op_b;
                add_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                add_a = op_a;
                add_b = op_b;
                if (lat_cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                add_a     = op_a;
                add_b     = op_b;
                rsp_valid = NREQ'(1) << gid;
                rsp_cout  = res_cout;
`ifdef ADDER_ARB_SAT_EN
                rsp_sum   = res_cout ? '1 : res_sum;
`else
                rsp_sum   = res_sum;
`endif
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, latency countdown, result capture and pointer advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            gid      <= '0;
            lat_cnt  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_hs) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                        gid  <= grant_idx;
                    end
                end
                ISSUE: begin
                    lat_cnt <= 3'(ADD_LAT - 1);
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        res_sum  <= add_sum;
                        res_cout <= add_cout;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        ptr <= (gid == IDXW'(NREQ - 1)) ? '0 : gid + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter
module tb_adder_arbiter;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 2;
`ifdef ADDER_ARB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   add_a, add_b, add_sum, rsp_sum;
    logic           add_start, add_cout, rsp_cout, busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_start (add_start),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // External adder: result valid only in the single cycle LAT cycles after add_start
    logic [W:0] pipe_d [LAT];
    logic       pipe_v [LAT];
    initial for (int k = 0; k < LAT; k++) begin pipe_v[k] = 1'b0; pipe_d[k] = '0; end
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_d[k] <= pipe_d[k-1];
            pipe_v[k] <= pipe_v[k-1];
        end
        pipe_d[0] <= {1'b0, add_a} + {1'b0, add_b};
        pipe_v[0] <= add_start;
    end
    assign add_sum  = pipe_v[LAT-1] ? pipe_d[LAT-1][W-1:0] : 16'hDEAD;
    assign add_cout = pipe_v[LAT-1] ? pipe_d[LAT-1][W]     : 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SAT && s[W]) s[W-1:0] = '1;
        return s;
    endfunction

    // Transaction-level reference: round-robin pick, then a fixed timeline per transaction
    bit         m_busy = 1'b0;
    int         m_cyc, m_id, m_ptr = 0;
    logic [W-1:0] m_a, m_b;
    always @(negedge clk) begin
        logic [W:0] e;
        int pick;
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_add_start", add_start, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_sum", rsp_sum, 0);
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            pick = -1;
            for (int off = 0; off < N; off++)
                if (pick < 0 && req_valid[(m_ptr + off) % N]) pick = (m_ptr + off) % N;
            chk("idle_req_ready", req_ready, pick < 0 ? 0 : (1 << pick));
            chk("idle_busy", busy, 0);
            chk("idle_add_start", add_start, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            if (pick >= 0) begin
                m_busy = 1'b1;
                m_cyc  = 0;
                m_id   = pick;
                m_a    = req_a[pick*W +: W];
                m_b    = req_b[pick*W +: W];
            end
        end else begin
            m_cyc++;
            e = ref_add(m_a, m_b);
            chk("busy_req_ready", req_ready, 0);
            chk("busy_busy", busy, 1);
            chk("busy_add_start", add_start, (m_cyc == 1) ? 1 : 0);
            chk("busy_add_a", add_a, m_a);
            chk("busy_add_b", add_b, m_b);
            if (m_cyc >= LAT + 2) begin
                chk("resp_valid", rsp_valid, 1 << m_id);
                chk("resp_sum", rsp_sum, e[W-1:0]);
                chk("resp_cout", rsp_cout, e[W]);
                if (rsp_ready[m_id]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_id + 1) % N;
                end
            end else begin
                chk("pre_rsp_valid", rsp_valid, 0);
                chk("pre_rsp_sum", rsp_sum, 0);
                chk("pre_rsp_cout", rsp_cout, 0);
            end
        end
    end

    logic [N-1:0] hs_v, s_rdy, s_rv;
    logic [W-1:0] s_sum, s_aa, s_ab;
    logic         s_cout, s_start;
    bit           persist = 1'b0;
    int           cyc = 0;

    // One clock: snapshot outputs at negedge, then retire handshaken requests after the edge
    task automatic step();
        @(negedge clk);
        hs_v    = req_valid & req_ready;
        s_rdy   = req_ready;
        s_rv    = rsp_valid;
        s_sum   = rsp_sum;
        s_cout  = rsp_cout;
        s_start = add_start;
        s_aa    = add_a;
        s_ab    = add_b;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs_v[i]) begin
                if (persist) begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int         hold;
        bit         wrong;
        logic [W-1:0] es;
        bit         ec;
    } vec_t;
    vec_t tbl[5];

    task automatic run_txn(input int k);
        int n;
        bit seen;
        vec_t v;
        v = tbl[k];
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        req_valid[v.id]    = 1'b1;
        rsp_ready          = '0;
        hs_v = '0;
        n = 0;
        while (hs_v[v.id] !== 1'b1 && n < 20) begin step(); n++; end
        chk($sformatf("vec%0d_granted", k), hs_v[v.id], 1);
        chk($sformatf("vec%0d_req_ready", k), s_rdy, 1 << v.id);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (n == 1) begin
                chk($sformatf("vec%0d_add_start", k), s_start, 1);
                chk($sformatf("vec%0d_add_a", k), s_aa, v.a);
                chk($sformatf("vec%0d_add_b", k), s_ab, v.b);
            end
            seen = s_rv[v.id];
        end
        chk($sformatf("vec%0d_latency", k), n, LAT + 2);
        chk($sformatf("vec%0d_rsp_sum", k), s_sum, v.es);
        chk($sformatf("vec%0d_rsp_cout", k), s_cout, v.ec);
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = (v.wrong && h == 2) ? ~(N'(1) << v.id) : '0;
            step();
            chk($sformatf("vec%0d_hold_valid", k), s_rv, 1 << v.id);
            chk($sformatf("vec%0d_hold_sum", k), s_sum, v.es);
            chk($sformatf("vec%0d_hold_ready", k), s_rdy, 0);
            chk($sformatf("vec%0d_hold_add_a", k), s_aa, v.a);
        end
        rsp_ready       = '0;
        rsp_ready[v.id] = 1'b1;
        step();
        rsp_ready = '0;
        chk($sformatf("vec%0d_done_busy", k), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ng, got, ack1;
        int g_id [5];
        int g_cyc [5];

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;

        tbl[0] = '{0, 16'hFFFF, 16'h0002, 0, 1'b0, SAT ? 16'hFFFF : 16'h0001, 1'b1};
        tbl[1] = '{1, 16'h8000, 16'h8000, 6, 1'b1, SAT ? 16'hFFFF : 16'h0000, 1'b1};
        tbl[2] = '{3, 16'h7FFF, 16'h0001, 3, 1'b1, 16'h8000, 1'b0};
        tbl[3] = '{0, 16'h0000, 16'h0000, 0, 1'b0, 16'h0000, 1'b0};
        tbl[4] = '{2, 16'h1234, 16'h0101, 0, 1'b0, 16'h1335, 1'b0};

        #2;
        chk("init_busy", busy, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        chk("init_add_start", add_start, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step();

        for (int k = 0; k < 5; k++) run_txn(k);

        // Reset during WAIT: pointer is 3 here, so a post-reset grant to 0 proves ptr cleared
        req_a[0*W +: W] = 16'h0003;
        req_b[0*W +: W] = 16'h0004;
        req_valid[0]    = 1'b1;
        rsp_ready       = '1;
        hs_v = '0;
        n = 0;
        while (!hs_v[0] && n < 20) begin step(); n++; end
        chk("mid_granted", hs_v[0], 1);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_add_start", add_start, 0);
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_add_b", add_b, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_sum", rsp_sum, 0);
        chk("mid_rst_rsp_cout", rsp_cout, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_no_rsp", s_rv, 0);
        end

        // Round-robin with all requesters continuously valid
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
        req_valid = '1;
        persist   = 1'b1;
        #1;
        chk("post_rst_first_grant", req_ready, 1);
        ng = 0;
        n  = 0;
        while (ng < 5 && n < 60) begin
            step();
            n++;
            for (int i = 0; i < N; i++)
                if (hs_v[i] && ng < 5) begin g_id[ng] = i; g_cyc[ng] = cyc; ng++; end
        end
        chk("rr_grant_count", ng, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_order%0d", k), g_id[k], k % N);
            if (k > 0) chk($sformatf("rr_spacing%0d", k), g_cyc[k] - g_cyc[k-1], LAT + 3);
        end
        persist   = 1'b0;
        req_valid = '0;
        repeat (10) step();

        // Withdrawn request: req1 pulses once while busy, req3 waits
        ack1 = 0;
        req_a[0*W +: W] = W'($urandom);
        req_valid[0]    = 1'b1;
        hs_v = '0;
        n = 0;
        while (!hs_v[0] && n < 20) begin step(); n++; end
        req_valid[1] = 1'b1;
        step();
        if (hs_v[1]) ack1++;
        req_valid[1]    = 1'b0;
        req_a[3*W +: W] = W'($urandom);
        req_valid[3]    = 1'b1;
        got = -1;
        n = 0;
        while (got < 0 && n < 30) begin
            step();
            n++;
            if (hs_v[1]) ack1++;
            for (int i = 0; i < N; i++) if (hs_v[i] && got < 0) got = i;
        end
        chk("wd_next_grant", got, 3);
        chk("wd_req1_acks", ack1, 0);
        repeat (10) step();

        // Randomized traffic with withdrawals, operand churn and random response backpressure
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 3) == 0) begin
                    req_valid[i]    = 1'b1;
                    req_a[i*W +: W] = (($urandom % 4) == 0) ? 16'hFFFF : W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                end else if (req_valid[i] && ($urandom % 16) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && ($urandom % 8) == 0) begin
                    req_a[i*W +: W] = W'($urandom);
                end
            end
            rsp_ready = N'($urandom);
            step();
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (15) step();
        chk("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin controller that shares one external adder among NREQ requesters.
- Accepts one operand pair per transaction and drives the adder.
- Waits the adder's fixed latency, then returns sum and carry to the requester that was granted.
- Sits between requester blocks and the shared adder datapath; one transaction in flight at a time.

Parameters:
WIDTH, 16, operand/sum width in bits
NREQ, 4, number of requesters (2..8)
ADD_LAT, 2, cycles from add_start to add_sum/add_cout valid (1..7)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester operand valid
req_a  input  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand B; same packing
req_ready  output  NREQ  one-hot accept; handshake = req_valid[i] & req_ready[i]
add_a  output  WIDTH  operand A to adder
add_b  output  WIDTH  operand B to adder
add_start  output  1  one-cycle launch pulse to adder
add_sum  input  WIDTH  adder result
add_cout  input  1  adder carry-out
rsp_valid  output  NREQ  one-hot response valid
rsp_sum  output  WIDTH  result for rsp_valid requester
rsp_cout  output  1  carry for rsp_valid requester
rsp_ready  input  NREQ  per-requester response accept
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst low, async): state=IDLE, ptr=0, lat_cnt=0, op/result/gid regs=0. All outputs 0. An in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: a one-hot bit for the first requester with req_valid set, searching from ptr upward modulo NREQ.
  - req_ready=0 if no req_valid is set.
  - On handshake: capture req_a/req_b slice into op_a/op_b and requester index into gid, then go to ISSUE.
- ISSUE:
  - add_start=1 for exactly one cycle.
  - add_a/add_b = op_a/op_b, held stable from ISSUE through RESP.
  - lat_cnt loads ADD_LAT-1, then go to WAIT.
- WAIT:
  - If lat_cnt==0: capture add_sum/add_cout into the result regs and go to RESP.
  - Otherwise decrement lat_cnt.
  - Result capture happens exactly ADD_LAT cycles after the add_start cycle.
- RESP:
  - rsp_valid[gid]=1; rsp_sum/rsp_cout come from the result regs, held stable.
  - Wait for rsp_ready[gid]. rsp_ready on other bits is ignored.
  - On handshake: ptr=(gid+1) mod NREQ, go to IDLE.
  - The next grant can occur in the cycle after the handshake.
- Outside RESP: rsp_valid=0, rsp_sum=0, rsp_cout=0. req_ready=0 outside IDLE.
- Latency: handshake to rsp_valid = ADD_LAT+2 cycles. Minimum period = ADD_LAT+3 cycles per transaction.
- Fairness: after requester k is served, k has lowest priority. With all NREQ valid continuously, grants go k+1, k+2, ... cyclically.
- Requesters may deassert req_valid before being granted; this has no side effects. Operands are sampled only on the handshake cycle.
- Arithmetic:
  - No computation inside this block; sum and carry are passed through from the adder.
  - rsp_cout reflects WIDTH-bit unsigned overflow as reported by the adder.

Optional Feature:
- Macro ADDER_ARB_SAT_EN.
- Defined: in RESP, if the captured add_cout=1, rsp_sum is forced to all ones (2^WIDTH-1); rsp_cout still reports 1.
- Undefined: rsp_sum is the raw wrapped add_sum.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: req0 a=0x0003 b=0x0004, then rst low during WAIT.
  - Required: all outputs 0 immediately; busy=0; no rsp_valid after release; next grant starts from requester 0.
- Single request:
  - Stimulus: req2 a=0x1234 b=0x0101, ADD_LAT=2, adder model, rsp_ready=1.
  - Required: req_ready=0b0100 on the handshake cycle; add_start one cycle later with add_a=0x1234, add_b=0x0101.
  - Required: rsp_valid=0b0100 at handshake+4 with rsp_sum=0x1335, rsp_cout=0.
- Round-robin with all four valid continuously:
  - Required: grant order 0,1,2,3,0.
  - Required: each response returns to the correct bit with sum a+b.
  - Required: grants spaced ADD_LAT+3=5 cycles apart.
- Response backpressure:
  - Stimulus: rsp_ready held low 6 cycles in RESP.
  - Required: rsp_valid, rsp_sum and add_a/add_b stable; req_ready=0 throughout.
  - Required: a wrong-bit rsp_ready pulse is ignored.
- Overflow:
  - Stimulus: a=0xFFFF, b=0x0002.
  - Required without ADDER_ARB_SAT_EN: rsp_sum=0x0001, rsp_cout=1.
  - Required with ADDER_ARB_SAT_EN: rsp_sum=0xFFFF, rsp_cout=1.
- Withdrawn request:
  - Stimulus: req1 valid one cycle while busy, then dropped; req3 held.
  - Required: req3 granted next; req1 never acknowledged.
